// File: rtl/stall_ctrl.sv
// -----------------------------------------------------------------------------
// stall_ctrl
//
// Hazard and stall controller for a 5-stage F/D/E/M/W pipeline.
//
// The D-stage source registers and their use-times are compared against the
// E- and M-stage destinations and result-times. A stall is raised when a
// source is needed sooner than forwarding can supply it, or when a mult/div
// family instruction in D finds the mult/div unit occupied. The stall freezes
// PC and REG_D and clears REG_E, so a bubble enters E at the next edge.
// M and W are never stalled or cleared here. A saturating counter records the
// total number of stalled cycles for performance debug.
//
// Ports
//   clk         in   1   clock, rising edge
//   reset       in   1   synchronous, active-high
//   rs_D        in   5   D-stage rs index
//   rt_D        in   5   D-stage rt index
//   tuse_rs_D   in   2   cycles until D needs rs (3 = never used)
//   tuse_rt_D   in   2   cycles until D needs rt (3 = never used)
//   md_D        in   1   D instr is mult/div/mfhi/mflo/mthi/mtlo
//   dst_E       in   5   E-stage write register (0 = none)
//   tnew_E      in   2   cycles until E result is forwardable
//   dst_M       in   5   M-stage write register (0 = none)
//   tnew_M      in   2   cycles until M result is forwardable
//   md_start_E  in   1   E-stage instr starts mult/div this cycle
//   md_div_E    in   1   1 = div/divu, 0 = mult/multu
//   stall       out  1   hazard detected this cycle
//   pc_en       out  1   PC write enable
//   d_en        out  1   REG_D enable
//   e_clr       out  1   REG_E clear (bubble insert)
//   md_busy     out  1   mult/div unit occupied
//   stall_cnt   out  32  stalled cycles since reset, saturating
// -----------------------------------------------------------------------------
module stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic        md_D,
    input  logic [4:0]  dst_E,
    input  logic [1:0]  tnew_E,
    input  logic [4:0]  dst_M,
    input  logic [1:0]  tnew_M,
    input  logic        md_start_E,
    input  logic        md_div_E,
    output logic        stall,
    output logic        pc_en,
    output logic        d_en,
    output logic        e_clr,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic [CNT_W-1:0] md_cnt;
    logic [31:0]      stall_total;
    logic             stall_rs;
    logic             stall_rt;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // A source hazard exists when the register is real (non-zero), matches a
    // pending write, and is needed before that write can be forwarded.
    // Because tuse is never negative, tnew == 0 can never satisfy tuse < tnew,
    // and a never-used source (tuse == 3) can never be below a 2-bit tnew.
    function automatic logic src_hazard(input logic [4:0] src,
                                        input logic [1:0] tuse,
                                        input logic [4:0] de,
                                        input logic [1:0] te,
                                        input logic [4:0] dm,
                                        input logic [1:0] tm);
        return (src != 5'd0) &&
               (((src == de) && (tuse < te)) || ((src == dm) && (tuse < tm)));
    endfunction

    always_comb begin
        stall_rs = src_hazard(rs_D, tuse_rs_D, dst_E, tnew_E, dst_M, tnew_M);
        stall_rt = src_hazard(rt_D, tuse_rt_D, dst_E, tnew_E, dst_M, tnew_M);
        // The start cycle itself counts as busy, so an instruction entering D
        // right behind a mult/div start is held.
        md_busy  = (md_cnt != '0) || md_start_E;
        stall    = stall_rs || stall_rt || (md_D && md_busy);
        pc_en    = ~stall;
        d_en     = ~stall;
        e_clr    = stall;
    end

    assign stall_cnt = stall_total;

    // A start is honoured even while e_clr is high: it belongs to the
    // instruction already in E, not to the one being held in D. A start while
    // the unit is still busy reloads the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt      <= '0;
            stall_total <= 32'd0;
        end else begin
            if (md_start_E)
                md_cnt <= md_div_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - CNT_W'(1);

            if (stall)
                stall_total <= sat_inc(stall_total);
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stall_ctrl
//
// Directed bench for stall_ctrl. Each stimulus cycle queues the hand-computed
// response (stall, md_busy, stall_cnt); a monitor samples the DUT on the
// falling edge, pops the queue and compares. pc_en, d_en and e_clr are checked
// against the expected stall in the same comparison.
// -----------------------------------------------------------------------------
module tb_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_D, rt_D, dst_E, dst_M;
    logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
    logic        md_D, md_start_E, md_div_E;
    logic        stall, pc_en, d_en, e_clr, md_busy;
    logic [31:0] stall_cnt;

    typedef struct {
        string       tag;
        logic        s;
        logic        b;
        logic [31:0] c;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .tuse_rs_D  (tuse_rs_D),
        .tuse_rt_D  (tuse_rt_D),
        .md_D       (md_D),
        .dst_E      (dst_E),
        .tnew_E     (tnew_E),
        .dst_M      (dst_M),
        .tnew_M     (tnew_M),
        .md_start_E (md_start_E),
        .md_div_E   (md_div_E),
        .stall      (stall),
        .pc_en      (pc_en),
        .d_en       (d_en),
        .e_clr      (e_clr),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (stall !== e.s || pc_en !== ~e.s || d_en !== ~e.s || e_clr !== e.s ||
                md_busy !== e.b || stall_cnt !== e.c)
                $display("FAIL %s: got stall=%b pc_en=%b d_en=%b e_clr=%b md_busy=%b stall_cnt=%h, required stall=%b md_busy=%b stall_cnt=%h",
                         e.tag, stall, pc_en, d_en, e_clr, md_busy, stall_cnt, e.s, e.b, e.c);
            else
                passed++;
        end
    end

    // Queue the expected response for the inputs just applied, then advance
    // to just after the next rising edge.
    task automatic chk(input string tag, input logic s, input logic b, input logic [31:0] c);
        exp_t e;
        e.tag = tag;
        e.s   = s;
        e.b   = b;
        e.c   = c;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs_D = 5'd0; rt_D = 5'd0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
        md_D = 1'b0; dst_E = 5'd0; tnew_E = 2'd0; dst_M = 5'd0; tnew_M = 2'd0;
        md_start_E = 1'b0; md_div_E = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("reset_state", 1'b0, 1'b0, 32'd0);

        // Load-use on E, then the same producer one stage later in M.
        dst_E = 5'd8; tnew_E = 2'd2; rs_D = 5'd8; tuse_rs_D = 2'd0;
        chk("load_use_E", 1'b1, 1'b0, 32'd0);
        dst_E = 5'd0; tnew_E = 2'd0; dst_M = 5'd8; tnew_M = 2'd1;
        chk("load_use_M", 1'b1, 1'b0, 32'd1);
        tnew_M = 2'd0;
        chk("tnew_M_zero", 1'b0, 1'b0, 32'd2);

        // Register 0 never stalls; unused source never stalls.
        idle_inputs();
        rs_D = 5'd0; dst_E = 5'd0; tnew_E = 2'd2; tuse_rs_D = 2'd0;
        chk("reg_zero", 1'b0, 1'b0, 32'd2);
        rs_D = 5'd8; dst_E = 5'd8; tnew_E = 2'd2; tuse_rs_D = 2'd3;
        chk("tuse_never", 1'b0, 1'b0, 32'd2);
        tuse_rs_D = 2'd1;
        chk("tuse_lt_tnew", 1'b1, 1'b0, 32'd2);
        tuse_rs_D = 2'd2;
        chk("tuse_eq_tnew", 1'b0, 1'b0, 32'd3);
        tuse_rs_D = 2'd0; tnew_E = 2'd0;
        chk("tnew_E_zero", 1'b0, 1'b0, 32'd3);

        // Mult: busy for the start cycle plus 5, with md_D held throughout.
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        md_start_E = 1'b1; md_div_E = 1'b0; md_D = 1'b1;
        chk("mult_start", 1'b1, 1'b1, 32'd0);
        md_start_E = 1'b0;
        chk("mult_busy1", 1'b1, 1'b1, 32'd1);
        chk("mult_busy2", 1'b1, 1'b1, 32'd2);
        chk("mult_busy3", 1'b1, 1'b1, 32'd3);
        chk("mult_busy4", 1'b1, 1'b1, 32'd4);
        chk("mult_busy5", 1'b1, 1'b1, 32'd5);
        chk("mult_done", 1'b0, 1'b0, 32'd6);

        // Div interrupted by reset on its 4th cycle.
        idle_inputs();
        md_start_E = 1'b1; md_div_E = 1'b1;
        chk("div_start", 1'b0, 1'b1, 32'd6);
        md_start_E = 1'b0;
        chk("div_c2", 1'b0, 1'b1, 32'd6);
        chk("div_c3", 1'b0, 1'b1, 32'd6);
        reset = 1'b1;
        chk("div_c4_reset", 1'b0, 1'b1, 32'd6);
        reset = 1'b0;
        chk("div_after_reset", 1'b0, 1'b0, 32'd0);

        // Full div: 11 busy cycles, idle on the 12th.
        md_start_E = 1'b1; md_div_E = 1'b1;
        chk("div_full_start", 1'b0, 1'b1, 32'd0);
        md_start_E = 1'b0;
        for (int i = 1; i <= 10; i++) chk($sformatf("div_full_c%0d", i + 1), 1'b0, 1'b1, 32'd0);
        chk("div_full_done", 1'b0, 1'b0, 32'd0);

        // A div start while a mult is running reloads the counter.
        md_start_E = 1'b1; md_div_E = 1'b0;
        chk("reload_mult", 1'b0, 1'b1, 32'd0);
        md_start_E = 1'b0;
        chk("reload_mid", 1'b0, 1'b1, 32'd0);
        md_start_E = 1'b1; md_div_E = 1'b1;
        chk("reload_div", 1'b0, 1'b1, 32'd0);
        md_start_E = 1'b0;
        for (int i = 1; i <= 10; i++) chk($sformatf("reload_c%0d", i), 1'b0, 1'b1, 32'd0);
        chk("reload_done", 1'b0, 1'b0, 32'd0);

        // rt hazard on M plus rs hazard on E: one stall, counter +1 per cycle.
        rt_D = 5'd5; dst_M = 5'd5; tuse_rt_D = 2'd0; tnew_M = 2'd1;
        rs_D = 5'd8; dst_E = 5'd8; tuse_rs_D = 2'd0; tnew_E = 2'd2;
        chk("dual_c1", 1'b1, 1'b0, 32'd0);
        chk("dual_c2", 1'b1, 1'b0, 32'd1);
        chk("dual_c3", 1'b1, 1'b0, 32'd2);
        idle_inputs();
        chk("dual_after", 1'b0, 1'b0, 32'd3);

        // rt hazard on E alone.
        rt_D = 5'd9; dst_E = 5'd9; tnew_E = 2'd2; tuse_rt_D = 2'd1;
        chk("rt_on_E", 1'b1, 1'b0, 32'd3);
        idle_inputs();
        chk("rt_after", 1'b0, 1'b0, 32'd4);

        // Saturation at all-ones.
        force dut.stall_total = 32'hFFFF_FFFE;
        tick();
        release dut.stall_total;
        chk("sat_preload", 1'b0, 1'b0, 32'hFFFF_FFFE);
        rs_D = 5'd8; dst_E = 5'd8; tnew_E = 2'd2; tuse_rs_D = 2'd0;
        chk("sat_c1", 1'b1, 1'b0, 32'hFFFF_FFFE);
        chk("sat_c2", 1'b1, 1'b0, 32'hFFFF_FFFF);
        chk("sat_c3", 1'b1, 1'b0, 32'hFFFF_FFFF);
        idle_inputs();
        chk("sat_hold", 1'b0, 1'b0, 32'hFFFF_FFFF);

        // Let the monitor drain the queue.
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending, required 0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
